uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares the single UART transmitter byte stream between N_REQ byte-stream requesters (firmware mailbox, LA-driven debug source, etc.).
- Sits between the requesters and the UART macro's TX data/ready port in the user project.
- Grants one requester at a time and holds the grant for a whole packet.
- Releases the grant on last-byte, burst limit, or idle timeout, so no requester can starve the others.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbitration slice.
package uart_pkg;

    localparam int UART_DW = 8;
    localparam int RR_MAX  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Reference round-robin pick: first set bit at or after ptr, wrapping modulo n.
    function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                           input logic [2:0]        ptr,
                                           input int                n);
        logic [2:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            if (!found && k < n && valid[(int'(ptr) + k) % n]) begin
                win   = 3'((int'(ptr) + k) % n);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: rotate by the pointer, priority-encode, unrotate.
module uart_rr_picker #(
    parameter int  N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic          any_o,
    output logic [PW-1:0] win_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;

    // NOTE: every variable written here gets a default first so no path infers a latch.
    always_comb begin
        dbl = {valid_i, valid_i};
        rot = dbl[ptr_i +: N];
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PW'(i);
            end
        end
        any_o = |valid_i;
        win_o = PW'((int'(ptr_i) + int'(off)) % N);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream between N_REQ requesters.
// A grant covers a packet and is dropped on last byte, burst limit or idle timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  N_REQ     = 4,
    parameter int  DW        = UART_DW,
    parameter int  MAX_BURST = 16,
    parameter int  TIMEOUT   = 32,
    localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    output logic [N_REQ-1:0]    req_ready,
    output logic                tx_valid,
    output logic [DW-1:0]       tx_data,
    input  logic                tx_ready,
    output logic [GW-1:0]       grant_id,
    output logic                busy,
    output logic                timeout_evt
);

    localparam int CW = 8;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] next_ptr;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          pick_any;
    logic [GW-1:0] pick_win;

    uart_rr_picker #(.N(N_REQ)) u_picker (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .any_o   (pick_any),
        .win_o   (pick_win)
    );

    // The index just served drops to lowest priority.
    assign next_ptr = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
    assign busy     = (state_q == GRANT);
    assign grant_id = grant_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        req_ready   = '0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        timeout_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    grant_d     = pick_win;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            GRANT: begin
                tx_valid           = req_valid[grant_q];
                tx_data            = req_data[int'(grant_q) * DW +: DW];
                req_ready[grant_q] = tx_ready;
                if (tx_valid && tx_ready) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                    idle_cnt_d  = '0;
                    if (req_last[grant_q] || burst_cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (!tx_valid) begin
                    // Back-pressure with valid high leaves idle_cnt untouched.
                    if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d     = IDLE;
                        rr_ptr_d    = next_ptr;
                        timeout_evt = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: per-cycle compare against a behavioural arbiter model,
// directed scenarios with literal expectations, then a randomized soak.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
    localparam int TOUT = 8;

    logic            clk;
    logic            wb_rst_i;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            tx_valid, tx_ready, busy, timeout_evt;
    logic [DW-1:0]   tx_data;
    logic [1:0]      grant_id;

    uart_tx_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MAXB), .TIMEOUT(TOUT)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester packet sources: bytes waiting per requester, with last flags.
    logic [7:0] qd[N][$];
    bit         ql[N][$];
    logic [N-1:0] acc_s;
    logic       rst_seen;
    bit         rand_mode = 0;
    int         gap_pct   = 0;
    int         pushed    = 0;

    // Transfer / timeout logs captured from the DUT outputs.
    int cyc = 0;
    int log_c[$], log_g[$], log_d[$], to_c[$];
    int rdy_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    int m_owner, m_gid, m_sent, m_idle, m_ptr;

    always @(posedge clk) begin : model_upd
        int o, g, s, id, p;
        bit found;
        o = m_owner; g = m_gid; s = m_sent; id = m_idle; p = m_ptr;
        if (wb_rst_i) begin
            o = -1; g = 0; s = 0; id = 0; p = 0;
        end else if (o < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[(p + k) % N]) begin
                    found = 1;
                    o = (p + k) % N; g = o; s = 0; id = 0;
                end
            end
        end else if (req_valid[o] && tx_ready) begin
            s  = s + 1;
            id = 0;
            if (req_last[o] || s == MAXB) begin
                p = (o + 1) % N; o = -1;
            end
        end else if (!req_valid[o]) begin
            id = id + 1;
            if (id == TOUT) begin
                p = (o + 1) % N; o = -1;
            end
        end
        m_owner <= o; m_gid <= g; m_sent <= s; m_idle <= id; m_ptr <= p;
    end

    // ---------------- compare process ----------------
    initial forever begin : compare
        logic          e_tv, e_to;
        logic [DW-1:0] e_td;
        logic [N-1:0]  e_rdy;
        @(negedge clk);
        acc_s = req_valid & req_ready;
        if (wb_rst_i === 1'b0) begin
            e_tv = 0; e_td = '0; e_rdy = '0; e_to = 0;
            if (m_owner >= 0) begin
                e_tv          = req_valid[m_owner];
                e_td          = req_data[m_owner*DW +: DW];
                e_rdy[m_owner] = tx_ready;
                e_to          = !req_valid[m_owner] && (m_idle == TOUT - 1);
            end
            check("busy",        busy,        m_owner >= 0);
            check("grant_id",    grant_id,    m_gid);
            check("tx_valid",    tx_valid,    e_tv);
            check("tx_data",     tx_data,     e_td);
            check("req_ready",   req_ready,   e_rdy);
            check("timeout_evt", timeout_evt, e_to);
            if (tx_valid && tx_ready) begin
                log_c.push_back(cyc); log_g.push_back(grant_id); log_d.push_back(tx_data);
            end
            if (timeout_evt) to_c.push_back(cyc);
            if (|req_ready) rdy_seen++;
        end
    end

    // ---------------- requester driver ----------------
    task automatic drive();
        if (rst_seen) begin
            for (int i = 0; i < N; i++) begin
                qd[i].delete(); ql[i].delete();
            end
            req_valid = '0; req_last = '0; req_data = '0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && acc_s[i]) begin
                void'(qd[i].pop_front()); void'(ql[i].pop_front());
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
            if (!req_valid[i] && qd[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = qd[i][0];
                req_last[i]          = ql[i][0];
            end
        end
        if (rand_mode) tx_ready = ($urandom_range(99) < 75);
    endtask

    initial forever begin
        @(posedge clk);
        rst_seen = wb_rst_i;
        #1;
        drive();
    end

    // ---------------- main sequence helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load(input int r, input logic [7:0] b0, input int len, input bit last_end);
        for (int k = 0; k < len; k++) begin
            qd[r].push_back(8'(b0 + k));
            ql[r].push_back(last_end && (k == len - 1));
        end
        pushed += len;
    endtask

    task automatic clear_logs();
        log_c.delete(); log_g.delete(); log_d.delete(); to_c.delete();
        pushed = 0;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (qd[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((!queues_empty() || busy) && k < budget) begin
            step(1);
            k++;
        end
        check(name, k < budget, 1'b1);
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int k = 0;
        while (log_d.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(name, k < budget, 1'b1);
    endtask

    task automatic apply_reset();
        wb_rst_i = 1'b1;
        step(2);
        wb_rst_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},      busy,          1'b0);
        check({tag, "_tx_valid"},  tx_valid,      1'b0);
        check({tag, "_tx_data"},   tx_data,       8'h00);
        check({tag, "_req_ready"}, req_ready,     4'h0);
        check({tag, "_grant_id"},  grant_id,      2'd0);
        check({tag, "_timeout"},   timeout_evt,   1'b0);
        check({tag, "_rr_ptr"},    dut.rr_ptr_q,  2'd0);
    endtask

    function automatic int lg(input int which, input int k);
        if (which == 0) return (k < log_c.size()) ? log_c[k] : -1;
        if (which == 1) return (k < log_g.size()) ? log_g[k] : -1;
        return (k < log_d.size()) ? log_d[k] : -1;
    endfunction

    // ---------------- scenarios ----------------
    initial begin : main
        int t0, t1, rdy0;
        logic [7:0] exp_d[6];
        int         exp_g[6];
        wb_rst_i = 1'b1; tx_ready = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0;
        step(3);
        wb_rst_i = 1'b0;
        check_reset_state("por");

        // Single requester, three-byte packet.
        clear_logs(); tx_ready = 1'b1;
        load(2, 8'hA1, 3, 1); t0 = cyc;
        wait_drain("single_drain", 50);
        check("single_count", log_d.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check("single_data",  lg(2, k), 32'hA1 + k);
            check("single_grant", lg(1, k), 2);
            check("single_cycle", lg(0, k), t0 + 2 + k);
        end
        check("single_rr_ptr", dut.rr_ptr_q, 2'd3);
        check("model_rr_ptr",  m_ptr, 3);

        // Fairness: every requester holds 1-byte packets.
        apply_reset(); clear_logs(); tx_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            load(i, 8'(8'hB0 + i), 1, 1);
            load(i, 8'(8'hC0 + i), 1, 1);
        end
        t0 = cyc;
        wait_drain("fair_drain", 100);
        for (int k = 0; k < 5; k++) begin
            check("fair_grant", lg(1, k), k % N);
            check("fair_cycle", lg(0, k), t0 + 2 + 2 * k);
        end
        check("fair_data4", lg(2, 4), 32'hC0);

        // Burst limit: requester 0 streams 10 bytes, requester 1 has one.
        apply_reset(); clear_logs(); tx_ready = 1'b1;
        load(0, 8'h10, 10, 1);
        load(1, 8'h55, 1, 1);
        wait_drain("burst_drain", 100);
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h55, 8'h14};
        exp_g = '{0, 0, 0, 0, 1, 0};
        check("burst_count", log_d.size(), 11);
        for (int k = 0; k < 6; k++) begin
            check("burst_data",  lg(2, k), exp_d[k]);
            check("burst_grant", lg(1, k), exp_g[k]);
        end

        // Back-pressure mid-packet for 50 cycles.
        apply_reset(); clear_logs(); tx_ready = 1'b1;
        load(3, 8'h60, 5, 1);
        wait_log("bp_start", 2, 20);
        tx_ready = 1'b0; rdy0 = rdy_seen;
        step(50);
        check("bp_no_xfer",    log_d.size(), 2);
        check("bp_no_timeout", to_c.size(), 0);
        check("bp_ready_low",  rdy_seen - rdy0, 0);
        tx_ready = 1'b1;
        wait_drain("bp_drain", 50);
        check("bp_count", log_d.size(), 5);
        for (int k = 0; k < 5; k++) check("bp_data", lg(2, k), 32'h60 + k);

        // Idle timeout after one byte; requester 2 is waiting.
        apply_reset(); clear_logs(); tx_ready = 1'b1;
        load(1, 8'h31, 1, 0);
        wait_log("to_first", 1, 20);
        t1 = lg(0, 0);
        load(2, 8'h42, 1, 1);
        wait_drain("to_drain", 100);
        check("to_events", to_c.size(), 1);
        check("to_cycle",  (to_c.size() > 0) ? to_c[0] : -1, t1 + TOUT);
        check("to_next_grant", lg(1, 1), 2);
        check("to_next_data",  lg(2, 1), 32'h42);
        check("to_next_cycle", lg(0, 1), t1 + TOUT + 2);

        // Reset during byte 2 of 5.
        apply_reset(); clear_logs(); tx_ready = 1'b1;
        load(2, 8'h70, 5, 1);
        wait_log("rst_first", 1, 20);
        wb_rst_i = 1'b1; tx_ready = 1'b0;
        step(1);
        wb_rst_i = 1'b0;
        check_reset_state("midrst");
        check("midrst_count", log_d.size(), 1);
        tx_ready = 1'b1;

        // Randomized soak.
        clear_logs(); rand_mode = 1; gap_pct = 40;
        for (int c = 0; c < 3000; c++) begin
            step(1);
            for (int i = 0; i < N; i++) begin
                if (qd[i].size() == 0 && $urandom_range(7) == 0)
                    load(i, 8'($urandom), $urandom_range(1, 6), $urandom_range(4) != 0);
            end
        end
        rand_mode = 0; tx_ready = 1'b1;
        wait_drain("rand_drain", 2000);
        check("rand_bytes", log_d.size(), pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
